// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: round-robin grant between CPU (port 0) and
// debug/loader (port 1). Writes complete in one cycle; reads return one cycle later.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [3:0]        wren0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [3:0]        wren1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wren,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {IDLE, READ_WAIT} state_t;

  state_t state, state_nxt;
  logic   last_q, last_nxt;
  logic   rd_id_q, rd_id_nxt;
  logic   winner;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      last_q <= 1'b1;
      rd_id_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      last_q <= last_nxt;
      rd_id_q <= rd_id_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last_q;
    rd_id_nxt = rd_id_q;
    winner    = 1'b0;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    rvalid0   = 1'b0;
    rvalid1   = 1'b0;
    rdata0    = '0;
    rdata1    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wren  = '0;
    // Outputs are forced quiet while rst is held, not just after the edge.
    if (!rst) begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            // On a tie, the port not granted last time wins.
            winner    = req1 && (!req0 || !last_q);
            gnt0      = !winner;
            gnt1      = winner;
            mem_addr  = winner ? addr1  : addr0;
            mem_wdata = winner ? wdata1 : wdata0;
            mem_wren  = winner ? wren1  : wren0;
            last_nxt  = winner;
            if (mem_wren == 4'b0000) begin
              state_nxt = READ_WAIT;
              rd_id_nxt = winner;
            end
          end
        end
        READ_WAIT: begin
          rvalid0   = !rd_id_q;
          rvalid1   = rd_id_q;
          rdata0    = rd_id_q ? '0 : mem_rdata;
          rdata1    = rd_id_q ? mem_rdata : '0;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: cycle-by-cycle vector table through a scoreboard
// queue, plus a hand-written asynchronous reset-during-read sequence.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic [3:0]  wren0 = '0, wren1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata = '0;
  logic [3:0]  mem_wren;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .wdata0(wdata0), .wren0(wren0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .addr1(addr1), .wdata1(wdata1), .wren1(wren1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic        r0;
    logic [31:0] a0, d0;
    logic [3:0]  w0;
    logic        r1;
    logic [31:0] a1, d1;
    logic [3:0]  w1;
    logic [31:0] mrd;
    logic        g0, g1, v0, v1;
    logic [31:0] rd0, rd1, ma, md;
    logic [3:0]  mw;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  function automatic vec_t mkv(string name, logic r, logic r0, logic [31:0] a0, logic [31:0] d0,
                               logic [3:0] w0, logic r1, logic [31:0] a1, logic [31:0] d1,
                               logic [3:0] w1, logic [31:0] mrd, logic g0, logic g1,
                               logic v0, logic v1, logic [31:0] rd0, logic [31:0] rd1,
                               logic [31:0] ma, logic [31:0] md, logic [3:0] mw);
    vec_t v;
    v.name = name; v.rst = r;
    v.r0 = r0; v.a0 = a0; v.d0 = d0; v.w0 = w0;
    v.r1 = r1; v.a1 = a1; v.d1 = d1; v.w1 = w1;
    v.mrd = mrd;
    v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1;
    v.rd0 = rd0; v.rd1 = rd1; v.ma = ma; v.md = md; v.mw = mw;
    return v;
  endfunction

  task automatic check(string name, logic [159:0] act, logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [159:0] pack_act();
    return {24'h0, gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_addr, mem_wdata, mem_wren};
  endfunction

  function automatic logic [159:0] pack_exp(vec_t v);
    return {24'h0, v.g0, v.g1, v.v0, v.v1, v.rd0, v.rd1, v.ma, v.md, v.mw};
  endfunction

  task automatic apply(vec_t v);
    vec_t e;
    @(posedge clk);
    #1;
    rst = v.rst;
    req0 = v.r0; addr0 = v.a0; wdata0 = v.d0; wren0 = v.w0;
    req1 = v.r1; addr1 = v.a1; wdata1 = v.d1; wren1 = v.w1;
    mem_rdata = v.mrd;
    sb.push_back(v);
    @(negedge clk);
    e = sb.pop_front();
    check(e.name, pack_act(), pack_exp(e));
  endtask

  initial begin
    // name rst | r0 a0 d0 w0 | r1 a1 d1 w1 | mrd | g0 g1 v0 v1 rd0 rd1 ma md mw
    vecs.push_back(mkv("rst_hold_req", 1, 1, 32'h10, 0, 0, 1, 32'h20, 0, 4'hF, 0,
                       0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv("rst_idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                       0, 0, 0, 0, 0, 0, 0, 0, 0));
    // single read on port 0
    vecs.push_back(mkv("rd0_grant", 0, 1, 32'h10, 0, 0, 0, 0, 0, 0, 0,
                       1, 0, 0, 0, 0, 0, 32'h10, 0, 0));
    vecs.push_back(mkv("rd0_data", 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF,
                       0, 0, 1, 0, 32'hDEADBEEF, 0, 0, 0, 0));
    // tie of writes right after reset alternates starting with port 0
    vecs.push_back(mkv("tie_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                       0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) begin
      logic p1;
      p1 = (i % 2) == 1;
      vecs.push_back(mkv($sformatf("tie_wr_%0d", i), 0,
                         1, 32'h100, 32'h11111111, 4'hF, 1, 32'h200, 32'h22222222, 4'hF, 0,
                         !p1, p1, 0, 0, 0, 0,
                         p1 ? 32'h200 : 32'h100, p1 ? 32'h22222222 : 32'h11111111, 4'hF));
    end
    // port 0 write vs port 1 read; last pointer = 1 so port 0 first
    vecs.push_back(mkv("mix_wr0", 0, 1, 32'h30, 32'h33, 4'hF, 1, 32'h40, 32'h55, 0, 0,
                       1, 0, 0, 0, 0, 0, 32'h30, 32'h33, 4'hF));
    vecs.push_back(mkv("mix_rd1", 0, 0, 0, 0, 0, 1, 32'h40, 32'h55, 0, 0,
                       0, 1, 0, 0, 0, 0, 32'h40, 32'h55, 0));
    vecs.push_back(mkv("mix_rv1", 0, 1, 32'h44, 0, 4'hF, 1, 32'h40, 32'h55, 0, 32'hCAFEF00D,
                       0, 0, 0, 1, 0, 32'hCAFEF00D, 0, 0, 0));
    // byte-lane write pass-through, FSM must stay in IDLE
    vecs.push_back(mkv("byte_wr1", 0, 0, 0, 0, 0, 1, 32'h24, 32'h0000ABCD, 4'h3, 0,
                       0, 1, 0, 0, 0, 0, 32'h24, 32'h0000ABCD, 4'h3));
    vecs.push_back(mkv("byte_wr_no_rv", 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h12345678,
                       0, 0, 0, 0, 0, 0, 0, 0, 0));
    // reset during READ_WAIT abandons the read
    vecs.push_back(mkv("rstrd_grant", 0, 0, 0, 0, 0, 1, 32'h50, 0, 0, 0,
                       0, 1, 0, 0, 0, 0, 32'h50, 0, 0));
    vecs.push_back(mkv("rstrd_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h99,
                       0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv("rstrd_tie", 0, 1, 32'h60, 32'h66, 4'hF, 1, 32'h70, 32'h77, 4'hF, 32'h99,
                       1, 0, 0, 0, 0, 0, 32'h60, 32'h66, 4'hF));
    vecs.push_back(mkv("rstrd_quiet", 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h99,
                       0, 0, 0, 0, 0, 0, 0, 0, 0));
    // idle bus
    for (int i = 0; i < 10; i++)
      vecs.push_back(mkv($sformatf("idle_%0d", i), 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0,
                         32'h5A5A0000 + 32'(i), 0, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (vecs[i]) apply(vecs[i]);

    // async reset: mid-cycle assertion must kill rvalid immediately
    @(posedge clk); #1;
    rst = 0; req0 = 1; addr0 = 32'h80; wdata0 = 32'h0; wren0 = 4'h0;
    req1 = 0; wren1 = 4'h0;
    @(negedge clk);
    check("async_grant", {159'h0, gnt0}, 160'h1);
    @(posedge clk); #1;
    req0 = 0; mem_rdata = 32'hA5A5A5A5;
    #1;
    check("async_rv_before", {127'h0, rvalid0, rdata0}, {127'h0, 1'b1, 32'hA5A5A5A5});
    #1 rst = 1;
    #1;
    check("async_rv_during", {127'h0, rvalid0, rdata0}, 160'h0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("async_rv_after", {126'h0, rvalid0, rvalid1, rdata0}, 160'h0);
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_leftover: got %0d expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
